// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// flush counter width and the scoreboard entry width helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  // Enough to hold FLUSH_CYCLES-1 for FLUSH_CYCLES in 1..3.
  localparam int FLUSH_CNT_W = 2;

  // A scoreboard entry is {valid, waddr}.
  function automatic int sb_entry_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow scoreboard of in-flight register writers (EXE, MEM, WB) and the
// read-after-write comparison against the instruction sitting in ID.
module hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit WB_BYPASS      = 1'b0,
  localparam int EW            = sb_entry_width(REG_ADDR_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en,
  input  logic [EW-1:0]             e_in,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_raddr1,
  input  logic [REG_ADDR_WIDTH-1:0] id_raddr2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  output logic                      raw_hazard
);

  logic [EW-1:0] e_q, m_q, w_q;
  logic [EW-1:0] e_d, m_d, w_d;
  logic          hz_rs1, hz_rs2;

  function automatic logic entry_hit(input logic [REG_ADDR_WIDTH-1:0] addr,
                                     input logic [EW-1:0]             entry);
    return entry[EW-1] && (entry[REG_ADDR_WIDTH-1:0] == addr);
  endfunction

  // Next entries: shift E->M->W on non-frozen cycles, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (shift_en) begin
      e_d = e_in;
      m_d = e_q;
      w_d = m_q;
    end
  end

  // Entry registers, cleared to invalid on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // A source conflicts with any valid in-flight writer not yet visible to ID.
  always_comb begin
    hz_rs1 = id_valid && id_use_rs1 && (id_raddr1 != '0) &&
             (entry_hit(id_raddr1, e_q) || entry_hit(id_raddr1, m_q) ||
              (!WB_BYPASS && entry_hit(id_raddr1, w_q)));
    hz_rs2 = id_valid && id_use_rs2 && (id_raddr2 != '0) &&
             (entry_hit(id_raddr2, e_q) || entry_hit(id_raddr2, m_q) ||
              (!WB_BYPASS && entry_hit(id_raddr2, w_q)));
    raw_hazard = hz_rs1 || hz_rs2;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller for the five-stage core: RAW stalls via the shadow
// scoreboard, memory-wait freeze, redirect flush sequencing, perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit WB_BYPASS      = 1'b0,
  parameter int FLUSH_CYCLES   = 1,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_raddr1,
  input  logic [REG_ADDR_WIDTH-1:0] id_raddr2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      id_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_waddr,
  input  logic                      exe_redirect,
  input  logic                      mem_busy,
  output logic                      pc_enable,
  output logic                      if_id_reg_enable,
  output logic                      bpu_clear_ctrl,
  output logic                      id_exe_bubble,
  output logic                      id_exe_enable,
  output logic                      exe_mem_enable,
  output logic                      mem_wb_enable,
  output logic [PERF_WIDTH-1:0]     stall_cycles,
  output logic [PERF_WIDTH-1:0]     flush_count
);

  localparam int EW = sb_entry_width(REG_ADDR_WIDTH);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                 state_q, state_d;
  state_e                 ret_state_q, ret_state_d;
  state_e                 cur_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_WIDTH-1:0]  stall_q, stall_d;
  logic [PERF_WIDTH-1:0]  flushes_q, flushes_d;
  logic                   shift_en;
  logic [EW-1:0]          e_in;
  logic                   raw_hazard;

  hazard_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .WB_BYPASS      (WB_BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .e_in       (e_in),
    .id_valid   (id_valid),
    .id_raddr1  (id_raddr1),
    .id_raddr2  (id_raddr2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .raw_hazard (raw_hazard)
  );

  // Next-state and control outputs; priority busy > redirect > flush > RAW > normal.
  always_comb begin
    state_d          = state_q;
    ret_state_d      = ret_state_q;
    flush_cnt_d      = flush_cnt_q;
    stall_d          = stall_q;
    flushes_d        = flushes_q;
    pc_enable        = 1'b1;
    if_id_reg_enable = 1'b1;
    bpu_clear_ctrl   = 1'b0;
    id_exe_bubble    = 1'b0;
    id_exe_enable    = 1'b1;
    exe_mem_enable   = 1'b1;
    mem_wb_enable    = 1'b1;
    shift_en         = 1'b1;
    e_in             = {id_valid && id_reg_wen && (id_reg_waddr != '0), id_reg_waddr};

    // A frozen cycle resumes whatever the pipe was doing before the freeze.
    cur_state = (state_q == ST_FREEZE) ? ret_state_q : state_q;

    if (rst) begin
      pc_enable        = 1'b0;
      if_id_reg_enable = 1'b0;
      bpu_clear_ctrl   = 1'b1;
      id_exe_bubble    = 1'b1;
      e_in             = '0;
    end else if (mem_busy) begin
      pc_enable        = 1'b0;
      if_id_reg_enable = 1'b0;
      id_exe_enable    = 1'b0;
      exe_mem_enable   = 1'b0;
      mem_wb_enable    = 1'b0;
      shift_en         = 1'b0;
      stall_d          = stall_q + PERF_WIDTH'(1);
      state_d          = ST_FREEZE;
      ret_state_d      = cur_state;
    end else begin
      state_d = cur_state;
      if (exe_redirect) begin
        bpu_clear_ctrl = 1'b1;
        id_exe_bubble  = 1'b1;
        e_in           = '0;
        flush_cnt_d    = FLUSH_LOAD;
        state_d        = (FLUSH_LOAD != '0) ? ST_FLUSH : ST_RUN;
        flushes_d      = flushes_q + PERF_WIDTH'(1);
      end else if (cur_state == ST_FLUSH) begin
        bpu_clear_ctrl = 1'b1;
        id_exe_bubble  = 1'b1;
        e_in           = '0;
        flush_cnt_d    = flush_cnt_q - FLUSH_CNT_W'(1);
        if (flush_cnt_q <= FLUSH_CNT_W'(1)) state_d = ST_RUN;
      end else if (raw_hazard) begin
        pc_enable        = 1'b0;
        if_id_reg_enable = 1'b0;
        id_exe_bubble    = 1'b1;
        e_in             = '0;
        stall_d          = stall_q + PERF_WIDTH'(1);
      end
    end
  end

  // FSM, flush counter and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ret_state_q <= ST_RUN;
      flush_cnt_q <= '0;
      stall_q     <= '0;
      flushes_q   <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_q     <= stall_d;
      flushes_q   <= flushes_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flushes_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan scenarios followed by
// random traffic, all checked against a register-readiness reference model.
module tb_pipe_hazard_ctrl;

  localparam int  AW  = 5;
  localparam bit  BYP = 1'b0;
  localparam int  FC  = 2;
  localparam int  PW  = 32;
  localparam int  READY_LAT = BYP ? 2 : 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs1, id_use_rs2, id_reg_wen;
  logic [AW-1:0] id_raddr1, id_raddr2, id_reg_waddr;
  logic          exe_redirect, mem_busy;
  logic          pc_enable, if_id_reg_enable, bpu_clear_ctrl, id_exe_bubble;
  logic          id_exe_enable, exe_mem_enable, mem_wb_enable;
  logic [PW-1:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles until each register's pending write is readable.
  int            ready_in [32];
  int            rem_flush;
  logic [PW-1:0] m_stall, m_flush;

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH (AW),
    .WB_BYPASS      (BYP),
    .FLUSH_CYCLES   (FC),
    .PERF_WIDTH     (PW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_raddr1        (id_raddr1),
    .id_raddr2        (id_raddr2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .id_reg_wen       (id_reg_wen),
    .id_reg_waddr     (id_reg_waddr),
    .exe_redirect     (exe_redirect),
    .mem_busy         (mem_busy),
    .pc_enable        (pc_enable),
    .if_id_reg_enable (if_id_reg_enable),
    .bpu_clear_ctrl   (bpu_clear_ctrl),
    .id_exe_bubble    (id_exe_bubble),
    .id_exe_enable    (id_exe_enable),
    .exe_mem_enable   (exe_mem_enable),
    .mem_wb_enable    (mem_wb_enable),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hazard();
    bit h1, h2;
    h1 = id_use_rs1 && (id_raddr1 != 0) && (ready_in[id_raddr1] > 0);
    h2 = id_use_rs2 && (id_raddr2 != 0) && (ready_in[id_raddr2] > 0);
    return id_valid && (h1 || h2);
  endfunction

  // Apply one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic do_cycle(input bit r, input bit v, input int a1, input int a2,
                          input bit u1, input bit u2, input bit we, input int wa,
                          input bit rd, input bit mb);
    logic [6:0] exp_ctrl, got_ctrl;
    bit         hz;
    @(negedge clk);
    rst = r; id_valid = v; id_raddr1 = AW'(a1); id_raddr2 = AW'(a2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_wen = we; id_reg_waddr = AW'(wa);
    exe_redirect = rd; mem_busy = mb;
    #1;
    hz = model_hazard();
    // {pc, if_id, clear, bubble, id_exe, exe_mem, mem_wb}
    if (r)                        exp_ctrl = 7'b0011111;
    else if (mb)                  exp_ctrl = 7'b0000000;
    else if (rd || rem_flush > 0) exp_ctrl = 7'b1111111;
    else if (hz)                  exp_ctrl = 7'b0001111;
    else                          exp_ctrl = 7'b1100111;
    got_ctrl = {pc_enable, if_id_reg_enable, bpu_clear_ctrl, id_exe_bubble,
                id_exe_enable, exe_mem_enable, mem_wb_enable};
    chk("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    @(posedge clk);
    if (r) begin
      foreach (ready_in[i]) ready_in[i] = 0;
      rem_flush = 0;
      m_stall   = '0;
      m_flush   = '0;
    end else if (mb) begin
      m_stall = m_stall + 1;
    end else begin
      foreach (ready_in[i]) if (ready_in[i] > 0) ready_in[i]--;
      if (rd) begin
        rem_flush = FC - 1;
        m_flush   = m_flush + 1;
      end else if (rem_flush > 0) begin
        rem_flush--;
      end else if (hz) begin
        m_stall = m_stall + 1;
      end else if (v && we && wa != 0) begin
        ready_in[wa] = READY_LAT;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (ready_in[i]) ready_in[i] = 0;
    rem_flush = 0;
    m_stall   = '0;
    m_flush   = '0;
    rst = 1'b1; id_valid = 1'b0; id_raddr1 = '0; id_raddr2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_wen = 1'b0; id_reg_waddr = '0;
    exe_redirect = 1'b0; mem_busy = 1'b0;
    @(posedge clk);
    #1;

    // Reset values.
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 1, 1, 2, 1, 1, 1, 3, 0, 0);

    // add x5,x1,x2 then sub x6,x5,x1: three stall cycles, then sub issues.
    do_cycle(0, 1, 1, 2, 1, 1, 1, 5, 0, 0);
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 5, 1, 1, 1, 1, 6, 0, 0);
    chk("raw_stall_len", stall_cycles, 32'd3);
    idle(3);

    // Writer to x0 then reader of x0; unused rs2 matching a writer.
    do_cycle(0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 1, 1, 1, 8, 0, 0);
    idle(3);
    do_cycle(0, 1, 1, 1, 1, 1, 1, 7, 0, 0);
    do_cycle(0, 1, 1, 7, 1, 0, 1, 9, 0, 0);
    chk("no_false_stall", stall_cycles, 32'd3);
    idle(3);

    // Redirect squashes ID writer x9; two clear cycles; x9 reader not blocked.
    do_cycle(0, 1, 1, 2, 1, 1, 1, 9, 1, 0);
    do_cycle(0, 1, 1, 2, 1, 1, 1, 10, 0, 0);
    do_cycle(0, 1, 9, 9, 1, 1, 0, 0, 0, 0);
    chk("flush_count_one", flush_count, 32'd1);
    idle(3);

    // RAW stall interrupted by a four-cycle memory freeze.
    do_cycle(0, 1, 1, 2, 1, 1, 1, 5, 0, 0);
    do_cycle(0, 1, 5, 1, 1, 1, 1, 6, 0, 0);
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 5, 1, 1, 1, 1, 6, 0, 1);
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 5, 1, 1, 1, 1, 6, 0, 0);
    idle(3);

    // Redirect and RAW hazard together: redirect wins, squashed writer x4 leaves no trace.
    do_cycle(0, 1, 1, 2, 1, 1, 1, 3, 0, 0);
    do_cycle(0, 1, 3, 1, 1, 1, 1, 4, 1, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 4, 4, 1, 1, 0, 0, 0, 0);
    idle(3);

    // Reset asserted during FLUSH aborts it.
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 1, 2, 1, 1, 1, 5, 0, 0);
    chk("post_reset_stall", stall_cycles, 32'd0);
    chk("post_reset_flush", flush_count, 32'd0);

    // Random traffic over a small register set to provoke frequent hazards.
    for (int i = 0; i < 600; i++) begin
      do_cycle(($urandom_range(0, 79) == 0),
               ($urandom_range(0, 7) != 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline controller for the five-stage NPC core. It sits beside the IF/ID/EXE/MEM/WB stage registers and drives their enables, flushes and bubbles. It tracks in-flight register writers in a shadow scoreboard to stall read-after-write hazards, because the core has no forwarding. It also freezes the pipe on memory wait and sequences branch/jump redirect flushes.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5: register index width.
- `WB_BYPASS`, 0: 1 means the register file is write-first, so a writer in WB causes no hazard.
- `FLUSH_CYCLES`, 1: IF/ID clear cycles per redirect; range 1..3.
- `PERF_WIDTH`, 32: performance counter width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction (the diffen bit of the IF/ID register).
- `id_raddr1`, `id_raddr2` in REG_ADDR_WIDTH each: ID source registers.
- `id_use_rs1`, `id_use_rs2` in 1 each: the source is actually read.
- `id_reg_wen` in 1: the ID instruction writes a register.
- `id_reg_waddr` in REG_ADDR_WIDTH: ID destination register.
- `exe_redirect` in 1: EXE resolved a taken branch or jump. EXE holds this asserted while the pipe is frozen.
- `mem_busy` in 1: LSU waiting on memory; the whole pipe must freeze.
- `pc_enable` out 1: PC register update.
- `if_id_reg_enable` out 1: IF/ID update.
- `bpu_clear_ctrl` out 1: clear IF/ID.
- `id_exe_bubble` out 1: load a NOP (all zero) into ID/EXE instead of the ID result.
- `id_exe_enable`, `exe_mem_enable`, `mem_wb_enable` out 1 each: downstream register updates.
- `stall_cycles`, `flush_count` out PERF_WIDTH each: performance counters.

## Operation
- The scoreboard is three shadow entries, E (EXE), M (MEM) and W (WB). Each entry holds `{valid, waddr}`.
- A hazard on rsN exists when all of the following hold: `id_valid & id_use_rsN & id_raddrN != 0`, and rsN matches a valid E or M entry, or a valid W entry when WB_BYPASS=0.
- FSM states:
  - RUN: normal flow.
  - FLUSH: count down FLUSH_CYCLES.
  - FREEZE: mem_busy.
- Priority per cycle is mem_busy > exe_redirect > flush counter > RAW hazard > normal.
- FREEZE condition (mem_busy=1): all enables are 0, bubble=0, clear=0. Scoreboard and counters hold, except stall_cycles increments. The FSM returns to the prior state when mem_busy drops.
- Redirect (exe_redirect=1, not busy):
  - Outputs: pc_enable=1, bpu_clear_ctrl=1, id_exe_bubble=1, downstream enables=1.
  - The flush counter loads FLUSH_CYCLES−1. If that value is nonzero, go to FLUSH.
  - flush_count increments.
  - The ID instruction is squashed, so E receives invalid.
- FLUSH: bpu_clear_ctrl=1 and id_exe_bubble=1; PC and downstream stages advance. Return to RUN when the counter reaches 0. A new redirect during FLUSH reloads the counter.
- RAW stall (hazard, not busy, no redirect, RUN):
  - Outputs: pc_enable=0, if_id_reg_enable=0, id_exe_bubble=1, downstream enables=1.
  - stall_cycles increments.
  - E receives invalid.
- Normal: all enables 1 and bubble 0. E receives `{id_valid & id_reg_wen & id_reg_waddr!=0, id_reg_waddr}`.
- The scoreboard shifts E→M→W on every non-frozen cycle; W's old content drops.
- The x0 destination never enters the scoreboard.
- Counters wrap modulo 2^PERF_WIDTH.

## Timing
- Control outputs are combinational from the current inputs and the registered state, and act at the next clk edge.
- Scoreboard, FSM, flush counter and perf counters update at posedge.
- While rst=1, outputs are: pc_enable=0, if_id_reg_enable=0, bpu_clear_ctrl=1, id_exe_bubble=1, and all downstream enables 1, so NOPs propagate.
- Reset values: scoreboard all invalid, FSM=RUN, flush counter=0, both counters 0.
- Reset mid-stall or mid-flush aborts the operation unconditionally.
- RAW stall length for a dependent pair issued back-to-back is 3 cycles with WB_BYPASS=0 and 2 cycles with WB_BYPASS=1.
- The redirect response has zero-cycle latency (same cycle as exe_redirect).

## Structure
- Shared package/header `define_pipelinectrl.vh` holds the FSM state encoding (RUN, FLUSH, FREEZE) and the scoreboard entry width.
- One sub-module, `hazard_scoreboard`: the three shadow entries plus the comparison logic. It outputs `raw_hazard`, with inputs `shift_en` and `e_in`.
- The FSM, flush counter and perf counters are in the top module.

## Test plan
- `add x5` followed immediately by `sub x6,x5,x1`, WB_BYPASS=0 -> pc_enable=0 and id_exe_bubble=1 for exactly 3 cycles, stall_cycles=3, then sub issues.
- Writer to x0, then a reader of x0 -> no stall. A reader with id_use_rs2=0 whose raddr2 matches -> no stall.
- exe_redirect pulse with FLUSH_CYCLES=2 -> bpu_clear_ctrl=1 and bubble=1 for 2 cycles, flush_count=1, the squashed ID writer never blocks a later reader.
- mem_busy held 4 cycles during a RAW stall -> all enables 0 and stall_cycles +4, then the RAW stall resumes with the remaining count unchanged.
- exe_redirect and a RAW hazard in the same cycle -> redirect wins; no stall; the scoreboard E entry is invalid.
- rst asserted during FLUSH -> next cycle the state is RUN with counters 0, and outputs match the reset values while rst=1.
